// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage hazard, forwarding and stall/flush sequencing controller
module ex_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int REG_AW      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_addr_srcA,
    input  logic              id_useA,
    input  logic [REG_AW-1:0] id_addr_srcB,
    input  logic              id_useB,
    input  logic [REG_AW-1:0] id_addr_dest,
    input  logic              id_WR,
    input  logic              id_mem_inst,
    input  logic              id_store,
    input  logic              id_mult,
    input  logic              ex_br,
    output logic              stall_if_id,
    output logic              flush_id,
    output logic              ex_valid,
    output logic [1:0]        fwdA_sel,
    output logic [1:0]        fwdB_sel,
    output logic              mult_busy,
    output logic              wb_WR_en
);

    logic [REG_AW-1:0] ex_dest, mem_dest, wb_dest;
    logic              ex_WR, ex_load;
    logic              mem_valid, mem_WR;
    logic              wb_valid, wb_WR;
    logic [3:0]        mult_cnt;

    logic              lu_a, lu_b, br_taken;
    logic              id_load, id_wr_eff;
    logic [1:0]        nxt_fwd_a, nxt_fwd_b;

    function automatic logic [1:0] pick_src(
        input logic              use_r,
        input logic [REG_AW-1:0] src,
        input logic              exv, input logic exw, input logic exl, input logic [REG_AW-1:0] exd,
        input logic              mv,  input logic mw,  input logic [REG_AW-1:0] md,
        input logic              wv,  input logic ww,  input logic [REG_AW-1:0] wd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_r) begin
            if (exv && exw && !exl && exd == src)
                sel = 2'b01;
            else if (mv && mw && md == src)
                sel = 2'b10;
            else if (wv && ww && wd == src)
                sel = 2'b11;
        end
        return sel;
    endfunction

    assign mult_busy = (mult_cnt != 4'd0);

    always_comb begin
        id_load   = id_mem_inst & ~id_store;
        // A store never writes the register file, so it can never be a forwarding source.
        id_wr_eff = id_WR & ~(id_mem_inst & id_store);
        lu_a      = id_valid & id_useA & ex_valid & ex_load & ex_WR & (ex_dest == id_addr_srcA);
        lu_b      = id_valid & id_useB & ex_valid & ex_load & ex_WR & (ex_dest == id_addr_srcB);
        br_taken  = ex_br & ex_valid & ~mult_busy;
        stall_if_id = mult_busy | (~br_taken & (lu_a | lu_b));
        flush_id    = br_taken;
        nxt_fwd_a = pick_src(id_useA, id_addr_srcA, ex_valid, ex_WR, ex_load, ex_dest,
                             mem_valid, mem_WR, mem_dest, wb_valid, wb_WR, wb_dest);
        nxt_fwd_b = pick_src(id_useB, id_addr_srcB, ex_valid, ex_WR, ex_load, ex_dest,
                             mem_valid, mem_WR, mem_dest, wb_valid, wb_WR, wb_dest);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_dest   <= '0;
            ex_WR     <= 1'b0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_dest  <= '0;
            mem_WR    <= 1'b0;
            wb_valid  <= 1'b0;
            wb_dest   <= '0;
            wb_WR     <= 1'b0;
            fwdA_sel  <= 2'b00;
            fwdB_sel  <= 2'b00;
            wb_WR_en  <= 1'b0;
            mult_cnt  <= 4'd0;
        end else begin
            wb_WR_en <= mem_valid & mem_WR;
            wb_valid <= mem_valid;
            wb_dest  <= mem_dest;
            wb_WR    <= mem_WR;
            if (mult_busy) begin
                // EX is frozen with the multiply; MEM drains to bubbles meanwhile.
                mem_valid <= 1'b0;
                mem_WR    <= 1'b0;
                mult_cnt  <= mult_cnt - 4'd1;
            end else begin
                mem_valid <= ex_valid;
                mem_dest  <= ex_dest;
                mem_WR    <= ex_WR;
                if (br_taken || lu_a || lu_b) begin
                    ex_valid <= 1'b0;
                    ex_WR    <= 1'b0;
                    ex_load  <= 1'b0;
                    fwdA_sel <= 2'b00;
                    fwdB_sel <= 2'b00;
                end else begin
                    ex_valid <= id_valid;
                    ex_dest  <= id_addr_dest;
                    ex_WR    <= id_valid & id_wr_eff;
                    ex_load  <= id_valid & id_load;
                    fwdA_sel <= id_valid ? nxt_fwd_a : 2'b00;
                    fwdB_sel <= id_valid ? nxt_fwd_b : 2'b00;
                    if (id_valid && id_mult)
                        mult_cnt <= 4'(MULT_CYCLES - 1);
                end
            end
        end
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline sequencing controller for the execute stage of the 16-bit-instruction, 8-register core.
- Tracks the instructions in EX, MEM and WB and selects operand forwarding for srcA/srcB.
- Stalls IF/ID on load-use hazards and for the duration of multi-cycle multiplies, and flushes ID on taken branches resolved in EX.
- Sits between the decode outputs and the EX datapath / register-file write port.

Parameters:
- MULT_CYCLES, 4: total EX cycles a multiply occupies; legal range 1..15.
- REG_AW, 3: register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- id_valid  in  1  valid instruction in ID.
- id_addr_srcA  in  REG_AW  srcA register of the ID instruction.
- id_useA  in  1  ID instruction reads srcA.
- id_addr_srcB  in  REG_AW  srcB register of the ID instruction.
- id_useB  in  1  ID instruction reads srcB.
- id_addr_dest  in  REG_AW  destination register.
- id_WR  in  1  ID instruction writes the register file.
- id_mem_inst  in  1  load/store.
- id_store  in  1  store (valid only with id_mem_inst).
- id_mult  in  1  multiply.
- ex_br  in  1  taken branch resolved in EX this cycle.
- stall_if_id  out  1  hold PC and the IF/ID register (combinational).
- flush_id  out  1  discard the IF/ID instruction (combinational).
- ex_valid  out  1  EX slot holds a real instruction (registered).
- fwdA_sel  out  2  srcA source for EX: 00 RF, 01 EX result, 10 MEM result, 11 WB result (registered).
- fwdB_sel  out  2  same encoding for srcB (registered).
- mult_busy  out  1  multiply in progress beyond its first EX cycle (registered).
- wb_WR_en  out  1  register-file write enable for WB (registered).

Behaviour:
- Pipeline tracking state:
  - ex_*, mem_*, wb_* each hold {valid, dest, WR, load}.
  - load = mem_inst & ~store.
- Reset (synchronous):
  - All valids 0 and mult_cnt 0.
  - fwdA_sel/fwdB_sel = 00; ex_valid, mult_busy, wb_WR_en = 0.
  - Reset mid-multiply or mid-stall aborts the operation; the next cycle is idle.
- Hazard terms (combinational):
  - luA = id_valid & id_useA & ex_valid & ex_load & ex_WR & (ex_dest == id_addr_srcA); luB is identical using srcB.
  - br_taken = ex_br & ex_valid & ~mult_busy.
  - mult_busy = (mult_cnt != 0).
- Priority per cycle, highest first:
  1. Multiply busy:
     - stall_if_id = 1; flush_id = 0.
     - EX holds its contents and fwd selects.
     - MEM <= bubble; WB <= MEM.
     - mult_cnt decrements.
  2. br_taken:
     - flush_id = 1; stall_if_id = 0.
     - EX <= bubble; MEM <= EX; WB <= MEM.
     - Any load-use hazard is ignored.
  3. luA | luB:
     - stall_if_id = 1.
     - EX <= bubble; MEM <= EX; WB <= MEM.
     - Exactly one stall cycle per load-use hazard.
  4. Normal advance:
     - EX <= ID instruction (valid = id_valid); MEM <= EX; WB <= MEM.
- Multiply start: when an instruction with id_mult enters EX, mult_cnt <= MULT_CYCLES-1. With MULT_CYCLES = 1 there is no stall.
- Forwarding selects are registered on every EX load (case 4 only) for srcA and srcB independently:
  - 01 if ex_valid & ex_WR & ~ex_load & ex_dest match;
  - else 10 if mem_valid & mem_WR & mem_dest match (includes load data);
  - else 11 if wb_valid & wb_WR & wb_dest match;
  - else 00.
  - A select is forced to 00 when the corresponding use bit is 0.
  - Bubbles load 00.
- wb_WR_en <= mem_valid & mem_WR on every cycle.
- ex_valid mirrors ex state.
- Stores never set WR-driven forwarding.
- All 8 registers are forwardable; there is no hardwired zero register.

Test Plan:
1. Back-to-back dependency: ADD r1 then ADD r2,r1,r3 -> second instruction in EX with fwdA_sel=01, fwdB_sel=00, no stall.
2. Distance 2 and 3: producer of r4, NOP, consumer r4 -> fwd 10. Two NOPs between -> fwd 11. A later producer of the same register wins (EX over MEM).
3. Load-use: LDR r2 then ADD r5,r2,r2 -> exactly 1 cycle stall_if_id=1 with an EX bubble (ex_valid=0), then ADD in EX with fwdA_sel=fwdB_sel=10.
4. Multiply, MULT_CYCLES=4: MUL in EX -> mult_busy and stall_if_id high for 3 cycles, EX held, MEM receives 3 bubbles, the next instruction enters EX on cycle 4. Repeat with MULT_CYCLES=1 -> zero stall.
5. Branch: ex_br=1 while the ID instruction is a load-use consumer -> flush_id=1, stall_if_id=0, next ex_valid=0. ex_br asserted during mult_busy -> ignored.
6. Reset pulse on the second cycle of a multiply -> next cycle all outputs 0, mult_cnt 0, and a fresh instruction advances normally.
